// File: rtl/seq_gen.sv
// seq_gen: serial sequence generator.
// Accepts a parallel word on a valid/ready handshake and shifts it out
// MSB-first (bit L-1 first), one bit per clock, optionally repeated
// back-to-back with no gap cycles. The FSM is a two-process Moore machine.
// Every output is a flop loaded from the next-state/next-datapath values,
// so the outputs depend only on registered state and have no
// combinational path from any input.
module seq_gen #(
   parameter int BW_DATA = 32,
   parameter int BW_LEN  = 6,
   parameter int BW_RPT  = 4
) (
   input  logic               i_clk,
   input  logic               i_rstn,
   input  logic [BW_DATA-1:0] i_data,
   input  logic [BW_LEN-1:0]  i_len,
   input  logic [BW_RPT-1:0]  i_rpt,
   input  logic               i_valid,
   output logic               o_ready,
   output logic               o_seq,
   output logic               o_seq_vld,
   output logic               o_busy,
   output logic               o_done
);

   // Bit-index width: just wide enough to address every bit of the word.
   localparam int BW_IDX = (BW_DATA > 1) ? $clog2(BW_DATA) : 1;

   // Length field constants, sized to the length field.
   localparam logic [BW_LEN-1:0] LEN_MAX = BW_LEN'(BW_DATA);
   localparam logic [BW_LEN-1:0] LEN_ONE = BW_LEN'(1);

   // Index and repeat-counter constants, sized to their registers.
   localparam logic [BW_IDX-1:0] IDX_ONE = BW_IDX'(1);
   localparam logic [BW_RPT-1:0] RPT_ONE = BW_RPT'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // FSM state.
   state_t state_reg;
   state_t state_next;

   // Datapath: captured word, current bit index, reload index (L-1)
   // and remaining repeat count.
   logic [BW_DATA-1:0] data_reg;
   logic [BW_DATA-1:0] data_next;
   logic [BW_IDX-1:0]  idx_reg;
   logic [BW_IDX-1:0]  idx_next;
   logic [BW_IDX-1:0]  top_reg;
   logic [BW_IDX-1:0]  top_next;
   logic [BW_RPT-1:0]  rpt_reg;
   logic [BW_RPT-1:0]  rpt_next;

   // Output flops.
   logic ready_reg;
   logic ready_next;
   logic seq_reg;
   logic seq_next;
   logic vld_reg;
   logic vld_next;
   logic busy_reg;
   logic busy_next;
   logic done_reg;
   logic done_next;

   // Effective length and the matching starting bit index.
   logic [BW_LEN-1:0] len_eff;
   logic [BW_IDX-1:0] len_top;

   // A length of zero, or one longer than the word, means "whole word".
   always_comb begin
      len_eff = i_len;
      if ((i_len == '0) || (i_len > LEN_MAX)) begin
         len_eff = LEN_MAX;
      end
      len_top = BW_IDX'(len_eff - LEN_ONE);
   end

   // Next-state, next-datapath and next-output decode.
   always_comb begin
      state_next = state_reg;
      data_next  = data_reg;
      idx_next   = idx_reg;
      top_next   = top_reg;
      rpt_next   = rpt_reg;

      case (state_reg)
         IDLE: begin
            if (i_valid) begin
               data_next  = i_data;
               idx_next   = len_top;
               top_next   = len_top;
               rpt_next   = i_rpt;
               state_next = SHIFT;
            end
         end

         SHIFT: begin
            if (idx_reg != '0) begin
               idx_next = idx_reg - IDX_ONE;
            end else if (rpt_reg != '0) begin
               // Reload straight into the next copy: no idle cycle.
               rpt_next = rpt_reg - RPT_ONE;
               idx_next = top_reg;
            end else begin
               state_next = DONE;
            end
         end

         DONE: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      // Outputs for the coming cycle, decoded from the coming state.
      ready_next = (state_next == IDLE);
      vld_next   = (state_next == SHIFT);
      busy_next  = (state_next == SHIFT) || (state_next == DONE);
      done_next  = (state_next == DONE);
      seq_next   = 1'b0;
      if (state_next == SHIFT) begin
         seq_next = data_next[idx_next];
      end
   end

   // State, datapath and output registers; reset wins over everything.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_reg <= IDLE;
         data_reg  <= '0;
         idx_reg   <= '0;
         top_reg   <= '0;
         rpt_reg   <= '0;
         ready_reg <= 1'b1;
         seq_reg   <= 1'b0;
         vld_reg   <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         data_reg  <= data_next;
         idx_reg   <= idx_next;
         top_reg   <= top_next;
         rpt_reg   <= rpt_next;
         ready_reg <= ready_next;
         seq_reg   <= seq_next;
         vld_reg   <= vld_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
      end
   end

   assign o_ready   = ready_reg;
   assign o_seq     = seq_reg;
   assign o_seq_vld = vld_reg;
   assign o_busy    = busy_reg;
   assign o_done    = done_reg;

endmodule

// File: tb/tb_seq_gen.sv
// Testbench for seq_gen: directed requests feed an expected-stream queue;
// a negedge monitor pops and compares every payload bit and done pulse.
// The driver separately checks cycle-exact handshake timing.
module tb_seq_gen;

   logic        i_clk;
   logic        i_rstn;
   logic [31:0] i_data;
   logic [5:0]  i_len;
   logic [3:0]  i_rpt;
   logic        i_valid;
   logic        o_ready;
   logic        o_seq;
   logic        o_seq_vld;
   logic        o_busy;
   logic        o_done;

   int checks = 0;
   int errors = 0;

   // Expected stream items: 0/1 = payload bit, 2 = done pulse.
   logic [1:0] exp_q[$];

   seq_gen #(
      .BW_DATA(32),
      .BW_LEN (6),
      .BW_RPT (4)
   ) dut (
      .i_clk    (i_clk),
      .i_rstn   (i_rstn),
      .i_data   (i_data),
      .i_len    (i_len),
      .i_rpt    (i_rpt),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .o_seq    (o_seq),
      .o_seq_vld(o_seq_vld),
      .o_busy   (o_busy),
      .o_done   (o_done)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Queue the expected stream for one request with hand-given length l.
   task automatic push_word(input logic [31:0] d, input int l, input int rpt);
      for (int r = 0; r <= rpt; r++) begin
         for (int b = l - 1; b >= 0; b--) begin
            exp_q.push_back({1'b0, d[b]});
         end
      end
      exp_q.push_back(2'd2);
   endtask

   // Stream monitor: compares whatever the DUT presents against the queue.
   always @(negedge i_clk) begin
      if (o_seq_vld === 1'b0) begin
         check("mon_idle_seq_zero", {31'b0, o_seq}, 32'd0);
      end
      if (o_seq_vld === 1'b1 && o_done === 1'b1) begin
         check("mon_vld_and_done", 32'd1, 32'd0);
      end else if (o_seq_vld === 1'b1 || o_done === 1'b1) begin
         logic [1:0] got;
         logic [1:0] e;
         got = (o_done === 1'b1) ? 2'd2 : {1'b0, o_seq};
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mon_unexpected: got %0d expected nothing at %0t", got, $time);
         end else begin
            e = exp_q.pop_front();
            check("mon_stream", {30'b0, got}, {30'b0, e});
         end
      end
   end

   // Full request with cycle-exact timing checks; l is the effective length.
   task automatic send(input logic [31:0] d, input logic [5:0] len, input logic [3:0] rpt,
                       input int l, input string tag);
      int guard;
      int n;
      guard = 0;
      while (o_ready !== 1'b1 && guard < 100) begin
         tick();
         guard++;
      end
      check({tag, "_ready_wait"}, {31'b0, o_ready}, 32'd1);
      i_valid = 1'b1;
      i_data  = d;
      i_len   = len;
      i_rpt   = rpt;
      push_word(d, l, int'(rpt));
      tick();
      // Inputs change while busy: must have no effect.
      i_valid = 1'b0;
      i_data  = ~d;
      i_len   = 6'd3;
      i_rpt   = 4'd7;
      n = l * (int'(rpt) + 1);
      for (int k = 1; k <= n; k++) begin
         check({tag, "_vld"}, {31'b0, o_seq_vld}, 32'd1);
         check({tag, "_busy"}, {31'b0, o_busy}, 32'd1);
         check({tag, "_not_ready"}, {31'b0, o_ready}, 32'd0);
         tick();
      end
      check({tag, "_done"}, {31'b0, o_done}, 32'd1);
      check({tag, "_done_busy"}, {31'b0, o_busy}, 32'd1);
      check({tag, "_done_vld"}, {31'b0, o_seq_vld}, 32'd0);
      check({tag, "_done_ready"}, {31'b0, o_ready}, 32'd0);
      tick();
      check({tag, "_ready_after"}, {31'b0, o_ready}, 32'd1);
      check({tag, "_done_cleared"}, {31'b0, o_done}, 32'd0);
      check({tag, "_idle_busy"}, {31'b0, o_busy}, 32'd0);
      $display("txn %s: data=%08h len=%0d rpt=%0d bits=%0d", tag, d, len, rpt, n);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      i_rstn  = 1'b0;
      i_valid = 1'b1;
      i_data  = 32'hFFFF_FFFF;
      i_len   = 6'd4;
      i_rpt   = 4'd0;

      // Reset with a concurrent request: reset must win.
      for (int k = 0; k < 3; k++) begin
         tick();
         check("rst_ready", {31'b0, o_ready}, 32'd1);
         check("rst_busy", {31'b0, o_busy}, 32'd0);
         check("rst_vld", {31'b0, o_seq_vld}, 32'd0);
         check("rst_seq", {31'b0, o_seq}, 32'd0);
         check("rst_done", {31'b0, o_done}, 32'd0);
      end
      i_valid = 1'b0;
      i_rstn  = 1'b1;
      tick();
      $display("txn reset: released");

      // 1: four bits 1,0,1,1.
      send(32'h0000_000B, 6'd4, 4'd0, 4, "s1");
      // 2: same word three times, contiguous.
      send(32'h0000_000B, 6'd4, 4'd2, 4, "s2");
      // 3: zero and oversize lengths both mean 32 bits.
      send(32'hA5A5_0F0F, 6'd0, 4'd0, 32, "s3_len0");
      send(32'hA5A5_0F0F, 6'd40, 4'd0, 32, "s3_len40");

      // 4: i_valid held high; data changes at T+2; re-accept at T+L+2.
      i_valid = 1'b1;
      i_data  = 32'h0000_000B;
      i_len   = 6'd4;
      i_rpt   = 4'd0;
      push_word(32'h0000_000B, 4, 0);
      tick();                          // T+1
      tick();                          // T+2
      i_data = 32'h0000_0003;
      push_word(32'h0000_0003, 4, 0);
      check("s4_busy_t2", {31'b0, o_busy}, 32'd1);
      for (int k = 0; k < 4; k++) tick();   // T+6
      check("s4_ready_t6", {31'b0, o_ready}, 32'd1);
      tick();                          // T+7: second word started
      i_valid = 1'b0;
      check("s4_second_vld", {31'b0, o_seq_vld}, 32'd1);
      check("s4_second_busy", {31'b0, o_busy}, 32'd1);
      for (int k = 0; k < 4; k++) tick();   // T+11
      check("s4_done", {31'b0, o_done}, 32'd1);
      tick();                          // T+12
      check("s4_ready_end", {31'b0, o_ready}, 32'd1);
      $display("txn s4: back-to-back 0000000b then 00000003");

      // 5: reset after the second bit of a 4-bit word.
      i_valid = 1'b1;
      i_data  = 32'h0000_000B;
      i_len   = 6'd4;
      i_rpt   = 4'd0;
      push_word(32'h0000_000B, 4, 0);
      tick();                          // T+1
      i_valid = 1'b0;
      tick();                          // T+2: second bit on the wire
      i_rstn = 1'b0;
      tick();                          // T+3
      i_rstn = 1'b1;
      check("s5_ready", {31'b0, o_ready}, 32'd1);
      check("s5_seq", {31'b0, o_seq}, 32'd0);
      check("s5_vld", {31'b0, o_seq_vld}, 32'd0);
      check("s5_busy", {31'b0, o_busy}, 32'd0);
      check("s5_done", {31'b0, o_done}, 32'd0);
      check("s5_discarded", exp_q.size(), 32'd3);
      exp_q.delete();
      for (int k = 0; k < 3; k++) begin
         tick();
         check("s5_no_done", {31'b0, o_done}, 32'd0);
      end
      $display("txn s5: reset mid-word, partial word discarded");
      send(32'h0000_000B, 6'd4, 4'd0, 4, "s5_fresh");

      // 6: one-bit word repeated 16 times, no wrap.
      send(32'h0000_0001, 6'd1, 4'd15, 1, "s6");
      for (int k = 0; k < 3; k++) begin
         tick();
         check("s6_quiet_vld", {31'b0, o_seq_vld}, 32'd0);
      end

      check("queue_empty", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_gen.md
Name: seq_gen

Overview:
Serial sequence generator: the transmit side of the single-bit sequence interface that the team's Moore/Mealy sequence detectors consume on i_seq. It accepts a parallel word through a valid/ready handshake and shifts it out MSB-first, one bit per clock, optionally repeated back-to-back. It serves as the reusable stimulus source in detector benches and as the serializer in top-level FSM labs.

Parameters:
BW_DATA, 32, width of the parallel word.
BW_LEN, 6, width of the length field; must satisfy 2^BW_LEN > BW_DATA.
BW_RPT, 4, width of the repeat-count field.

Ports:
i_clk  input  1  clock; all logic on rising edge.
i_rstn  input  1  reset, synchronous, active-low.
i_data  input  BW_DATA  word to serialize; bit i_len-1 goes out first.
i_len  input  BW_LEN  number of bits to send, 1..BW_DATA.
i_rpt  input  BW_RPT  extra repetitions of the word; 0 = send once.
i_valid  input  1  request; a transfer is accepted when i_valid & o_ready at a rising edge.
o_ready  output  1  high only in IDLE.
o_seq  output  1  serial bit; 0 whenever o_seq_vld=0.
o_seq_vld  output  1  o_seq carries a payload bit this cycle.
o_busy  output  1  high in SHIFT and DONE.
o_done  output  1  one-cycle pulse after the final bit.

Behaviour:
- Reset (i_rstn=0 at edge): state=IDLE, o_ready=1, o_seq=0, o_seq_vld=0, o_busy=0, o_done=0. Internal data, bit index, and repeat counter cleared. Reset has priority over everything, including a concurrent i_valid.
- All outputs are registered and decoded from state plus registered datapath only (Moore). No combinational path from inputs to outputs.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: when i_valid=1, capture i_data, effective length L, and i_rpt. Set bit index = L-1, then go to SHIFT. Otherwise stay in IDLE.
- Length rule: i_len=0 or i_len>BW_DATA gives L=BW_DATA. Otherwise L=i_len.
- SHIFT: each cycle drives o_seq=data[idx] with o_seq_vld=1.
  - idx>0: decrement idx.
  - idx=0 and repeat counter>0: decrement the counter and reload idx=L-1. There is no gap cycle; the repeated word is contiguous.
  - idx=0 and repeat counter=0: go to DONE.
- DONE: one cycle with o_done=1, o_seq_vld=0, o_seq=0, o_busy=1, o_ready=0. Unconditionally returns to IDLE.
- Timing for acceptance at edge T:
  - payload on cycles T+1 .. T+L*(i_rpt+1);
  - o_done on the following cycle;
  - o_ready=1 on the cycle after that.
- Inputs i_data, i_len, and i_rpt are sampled only at acceptance. Changes while busy have no effect.
- i_valid while o_ready=0 is ignored; it is not queued. The requester must hold i_valid until the handshake completes.
- Reset mid-operation: the next cycle shows reset values. No o_done is generated, and the partial word is discarded.
- Bit index and repeat counter never underflow or wrap. Maximum stream length is BW_DATA*(2^BW_RPT).

Test Plan:
1. Reset released, i_data=32'h0000_000B, i_len=4, i_rpt=0, accept at T -> o_seq=1,0,1,1 with o_seq_vld=1 on T+1..T+4; o_done=1 at T+5; o_ready=1 at T+6.
2. Same word with i_rpt=2 -> 12 contiguous valid bits 1011_1011_1011 on T+1..T+12, no gap cycles; o_done at T+13; o_busy=1 on T+1..T+13.
3. i_data=32'hA5A5_0F0F with i_len=0, then again with i_len=40 -> both runs send 32 bits, MSB-first, starting 1,0,1,0,0,1,0,1; o_done at T+33.
4. i_valid held high continuously, with i_data changed to 32'h3 at T+2 -> first word is unaffected; second acceptance occurs exactly at T+L+2 with i_data=32'h3.
5. Assert i_rstn=0 for one edge after the 2nd bit of a 4-bit word -> next cycle o_ready=1 and all other outputs 0; no o_done pulse; a fresh request afterwards behaves as in scenario 1.
6. i_len=1, i_data=1, i_rpt=15 -> 16 consecutive o_seq=1 bits, then o_done; repeat counter does not wrap to a 17th bit.
